// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// instruction width and the default word driven while not streaming.
package instr_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/instr_seq_mem.sv
// Program buffer: DEPTH x 32 words, one synchronous write port, asynchronous
// read, no reset so the loaded program survives rst.
module instr_seq_mem
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Streams a loaded program, one registered word per clock, into the CPU.
// Define INSTR_SEQ_STATS_EN to add zero/overflow result counters.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                 DEPTH    = 128,
    parameter int                 AW       = 7,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [AW:0]        prog_len,
    input  logic               start,
    input  logic               stall,
    output logic [INSTR_W-1:0] Instruction,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic               busy,
    output logic               done
`ifdef INSTR_SEQ_STATS_EN
    ,
    input  logic [31:0]        alu_result,
    input  logic               zero,
    input  logic               overflow,
    output logic [15:0]        zero_cnt,
    output logic [15:0]        ovf_cnt
`endif
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [AW-1:0]      idx;
    logic [AW:0]        len;
    logic [AW:0]        eff_len;
    logic               start_ok;
    logic               last;
    logic               issue;
    logic               mem_we;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;

    assign eff_len  = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign start_ok = (state == ST_IDLE) && start && (eff_len != '0);
    assign last     = ({1'b0, idx} == (len - 1'b1));
    assign issue    = (state == ST_RUN) && !stall;
    // The program is frozen while the CPU is consuming it.
    assign mem_we   = load_en && (state != ST_RUN);
    // Outside RUN the only word ever needed next is mem[0].
    assign rd_addr  = (state == ST_RUN) ? (idx + 1'b1) : '0;

    instr_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = ST_RUN;
            ST_RUN:  if (issue && last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
        pc   = '0;
        if (state == ST_RUN) begin
            pc = {{(30-AW){1'b0}}, idx, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            len         <= '0;
            Instruction <= NOP_WORD;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len         <= eff_len;
                        idx         <= '0;
                        Instruction <= rd_data;
                        instr_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (last) begin
                            idx         <= '0;
                            Instruction <= NOP_WORD;
                            instr_valid <= 1'b0;
                        end else begin
                            idx         <= idx + 1'b1;
                            Instruction <= rd_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_SEQ_STATS_EN
    // The CPU result for a word is observed the cycle after it was issued.
    logic issued_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
        return (en && (cnt != 16'hFFFF)) ? (cnt + 16'd1) : cnt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_p1 <= 1'b0;
            zero_cnt  <= '0;
            ovf_cnt   <= '0;
        end else begin
            issued_p1 <= issue;
            if (start_ok) begin
                zero_cnt <= '0;
                ovf_cnt  <= '0;
            end else if (issued_p1) begin
                zero_cnt <= sat_inc(zero_cnt, zero);
                ovf_cnt  <= sat_inc(ovf_cnt, overflow);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a behavioural model pushes the
// expected outputs per cycle into a scoreboard, plus directed program checks.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int          DEPTH = 128;
    localparam int          AW    = 7;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] W0    = 32'h0128_4020;
    localparam logic [31:0] W1    = 32'h0169_5820;
    localparam logic [31:0] W2    = 32'h018D_6020;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, load_en, start, stall;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [AW:0]   prog_len;
    logic [31:0]   Instruction, pc;
    logic          instr_valid, busy, done;
`ifdef INSTR_SEQ_STATS_EN
    logic [31:0]   alu_result;
    logic          zero, overflow;
    logic [15:0]   zero_cnt, ovf_cnt;
`endif

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .stall       (stall),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
`ifdef INSTR_SEQ_STATS_EN
        ,
        .alu_result  (alu_result),
        .zero        (zero),
        .overflow    (overflow),
        .zero_cnt    (zero_cnt),
        .ovf_cnt     (ovf_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: 0 idle, 1 run, 2 done
    int          m_state = 0;
    int          m_idx   = 0;
    int          m_len   = 0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_instr = NOP;
    logic        m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int   eff;
        int   old_state;
        exp_t e;
        old_state = m_state;
        eff = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
        if (rst) begin
            m_state = 0; m_idx = 0; m_instr = NOP; m_valid = 1'b0;
        end else begin
            case (m_state)
                0: if (start && eff > 0) begin
                    m_state = 1; m_len = eff; m_idx = 0;
                    m_instr = m_mem[0]; m_valid = 1'b1;
                end
                1: if (!stall) begin
                    if (m_idx == m_len - 1) begin
                        m_state = 2; m_idx = 0; m_instr = NOP; m_valid = 1'b0;
                    end else begin
                        m_idx++;
                        m_instr = m_mem[m_idx];
                    end
                end
                default: m_state = 0;
            endcase
        end
        if (load_en && old_state != 1) m_mem[load_addr] = load_data;
        e.instr = m_instr;
        e.valid = m_valid;
        e.pc    = (m_state == 1) ? 32'(m_idx * 4) : 32'd0;
        e.busy  = (m_state == 1);
        e.done  = (m_state == 2);
        sb.push_back(e);
    endtask

    // One clock: predict, advance, then compare the DUT against the prediction.
    task automatic cyc();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_instr", Instruction, e.instr);
        check("sb_valid", 32'(instr_valid), 32'(e.valid));
        check("sb_pc", pc, e.pc);
        check("sb_busy", 32'(busy), 32'(e.busy));
        check("sb_done", 32'(done), 32'(e.done));
    endtask

    task automatic load(input int a, input logic [31:0] d);
        load_en = 1'b1; load_addr = AW'(a); load_data = d;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic run_three(input string tag);
        prog_len = 8'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        check({tag, "_w0"}, Instruction, W0);
        check({tag, "_pc0"}, pc, 32'h0);
        cyc();
        check({tag, "_w1"}, Instruction, W1);
        check({tag, "_pc1"}, pc, 32'h4);
        cyc();
        check({tag, "_w2"}, Instruction, W2);
        check({tag, "_pc2"}, pc, 32'h8);
        cyc();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_nop"}, Instruction, NOP);
        check({tag, "_vld0"}, 32'(instr_valid), 32'd0);
        cyc();
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_prog(input logic [AW:0] len, input int exp_lat, input int exp_issues);
        int n;
        int issues;
        prog_len = len; start = 1'b1;
        cyc();
        start = 1'b0;
        n = 1;
        issues = instr_valid ? 1 : 0;
        while (!done && n < 400) begin
            cyc();
            n++;
            if (instr_valid) issues++;
        end
        check("run_latency", n, exp_lat);
        check("run_issues", issues, exp_issues);
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; start = 1'b0; stall = 1'b0;
        load_addr = '0; load_data = '0; prog_len = '0;
`ifdef INSTR_SEQ_STATS_EN
        alu_result = '0; zero = 1'b0; overflow = 1'b0;
`endif
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_instr", Instruction, NOP);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        for (int i = 0; i < DEPTH; i++) load(i, {8'hA5, 8'(i), 16'h5A5A});
        load(0, W0);
        load(1, W1);
        load(2, W2);

        // Plain three-word program
        run_three("basic");

        // Two stall cycles on the second word
        prog_len = 8'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("stall_w1_a", Instruction, W1);
        stall = 1'b1;
        cyc();
        check("stall_w1_b", Instruction, W1);
        check("stall_pc_b", pc, 32'h4);
        cyc();
        check("stall_w1_c", Instruction, W1);
        check("stall_pc_c", pc, 32'h4);
        stall = 1'b0;
        cyc();
        check("stall_w2", Instruction, W2);
        cyc();
        check("stall_done", 32'(done), 32'd1);
        cyc();

        // Zero length start is ignored
        prog_len = 8'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_valid", 32'(instr_valid), 32'd0);
        cyc();
        check("len0_done", 32'(done), 32'd0);

        // Oversized length clamps to DEPTH
        run_prog(8'd200, DEPTH + 1, DEPTH);
        run_prog(8'd5, 6, 5);

        // Reset on the second RUN cycle, then restart from the preserved buffer
        prog_len = 8'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_instr", Instruction, NOP);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        cyc();
        check("midrst_nodone", 32'(done), 32'd0);
        run_three("restart");

        // Load during RUN must not alter the program
        prog_len = 8'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        load_en = 1'b1; load_addr = 7'd1; load_data = 32'hDEAD_BEEF;
        cyc();
        load_en = 1'b0;
        check("runload_w1", Instruction, W1);
        cyc();
        cyc();
        check("runload_done", 32'(done), 32'd1);
        cyc();
        run_three("after_runload");

`ifdef INSTR_SEQ_STATS_EN
        prog_len = 8'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        zero = 1'b1; overflow = 1'b1;
        cyc();
        zero = 1'b1; overflow = 1'b0;
        cyc();
        zero = 1'b0;
        cyc();
        check("stats_zero", 32'(zero_cnt), 32'd2);
        check("stats_ovf", 32'(ovf_cnt), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("stats_zero_clr", 32'(zero_cnt), 32'd0);
        check("stats_ovf_clr", 32'(ovf_cnt), 32'd0);
        cyc();
        cyc();
        cyc();
        cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
